// File: rtl/module_multiword_add_ctrl.sv
// Serial multi-word adder: one shared RCAWIDE-bit ripple-carry slice processes
// one word per clock, LSW first, behind a start/done valid-ready handshake.

module module_ripple_carry_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);
  logic [WIDTH:0] c;

  assign c[0] = carry_i;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign carry_o = c[WIDTH];
endmodule

module module_multiword_add_ctrl #(
  parameter int RCAWIDE = 8,
  parameter int NWORDS  = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [RCAWIDE*NWORDS-1:0]   a_i,
  input  logic [RCAWIDE*NWORDS-1:0]   b_i,
  input  logic                        carry_i,
  input  logic                        start_valid_i,
  output logic                        start_ready_o,
  output logic [RCAWIDE*NWORDS-1:0]   sum_o,
  output logic                        carry_o,
  output logic                        done_valid_o,
  input  logic                        done_ready_i,
  output logic                        busy_o
);
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                           state_q;
  logic [IW-1:0]                    idx_q;
  logic                             cy_q;
  logic                             cout_q;
  logic [NWORDS-1:0][RCAWIDE-1:0]   a_q, b_q, sum_q;

  logic [RCAWIDE-1:0]               rca_sum;
  logic                             rca_cout;

  module_ripple_carry_adder #(.WIDTH(RCAWIDE)) u_rca (
    .a_i     (a_q[idx_q]),
    .b_i     (b_q[idx_q]),
    .carry_i (cy_q),
    .sum_o   (rca_sum),
    .carry_o (rca_cout)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      cout_q  <= 1'b0;
      sum_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_valid_i) begin
          a_q     <= a_i;
          b_q     <= b_i;
          cy_q    <= carry_i;
          idx_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          sum_q[idx_q] <= rca_sum;
          cy_q         <= rca_cout;
          // carry_o gets its own register so it only moves when a result completes
          if (idx_q == LAST) begin
            cout_q  <= rca_cout;
            idx_q   <= '0;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        DONE: if (done_ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_ready_o = (state_q == IDLE);
  assign done_valid_o  = (state_q == DONE);
  assign busy_o        = (state_q != IDLE);
  assign sum_o         = sum_q;
  assign carry_o       = cout_q;
endmodule

// File: tb/tb_module_multiword_add_ctrl.sv
// Randomized and directed bench for module_multiword_add_ctrl (RCAWIDE=8, NWORDS=4),
// checked against a plain-arithmetic model {carry,sum} = a + b + cin.

module tb_module_multiword_add_ctrl;
  localparam int RW = 8;
  localparam int NW = 4;
  localparam int W  = RW * NW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  a, b, sum;
  logic          cin, cout;
  logic          start_valid, start_ready, done_valid, done_ready, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_accept = -1000;

  module_multiword_add_ctrl #(.RCAWIDE(RW), .NWORDS(NW)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .a_i           (a),
    .b_i           (b),
    .carry_i       (cin),
    .start_valid_i (start_valid),
    .start_ready_o (start_ready),
    .sum_o         (sum),
    .carry_o       (cout),
    .done_valid_o  (done_valid),
    .done_ready_i  (done_ready),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one addition, wait for completion, check latency and result, then
  // hold done_ready low for 'stall' DONE cycles before accepting.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, input int stall, input string name);
    logic [W:0] exp;
    int n;
    exp = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
    checks++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s start_ready: got %b want 1", name, start_ready);
    end
    a = av; b = bv; cin = ci; start_valid = 1'b1;
    tick();
    checks++;
    if (cyc - last_accept < NW + 2) begin
      errors++;
      $display("FAIL %s issue_interval: got %0d want >=%0d", name, cyc - last_accept, NW + 2);
    end
    last_accept = cyc;
    start_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom);
    n = 0;
    while (done_valid !== 1'b1 && n < 20) begin
      checks++;
      if (busy !== 1'b1 || start_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s run_flags: busy=%b ready=%b want 1/0", name, busy, start_ready);
      end
      tick();
      n++;
    end
    checks++;
    if (n !== NW) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, n, NW);
    end
    checks++;
    if ({cout, sum} !== exp) begin
      errors++;
      $display("FAIL %s result: got %b_%h want %b_%h", name, cout, sum, exp[W], exp[W-1:0]);
    end
    for (int s = 0; s < stall; s++) begin
      done_ready = 1'b0;
      start_valid = 1'($urandom);
      tick();
      checks++;
      if (done_valid !== 1'b1 || {cout, sum} !== exp) begin
        errors++;
        $display("FAIL %s stall_hold: dv=%b got %h want %h", name, done_valid, {cout, sum}, exp);
      end
    end
    start_valid = 1'b0;
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    checks++;
    if (start_ready !== 1'b1 || done_valid !== 1'b0 || busy !== 1'b0 || {cout, sum} !== exp) begin
      errors++;
      $display("FAIL %s idle_hold: rdy=%b dv=%b busy=%b got %h want %h",
               name, start_ready, done_valid, busy, {cout, sum}, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    checks++;
    if (start_ready !== 1'b1 || done_valid !== 1'b0 || busy !== 1'b0 ||
        sum !== 32'h0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b dv=%b busy=%b sum=%h cout=%b want 1 0 0 00000000 0",
               start_ready, done_valid, busy, sum, cout);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_word_carry();
    do_op(32'h000000FF, 32'h00000001, 1'b0, 0, "word_carry");
  endtask

  task automatic test_full_ripple();
    do_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 0, "full_ripple");
  endtask

  task automatic test_done_stall();
    // stall phase pulses start_valid with random a/b; the request must be ignored
    do_op(32'h12345678, 32'h11111111, 1'b0, 10, "done_stall");
    checks++;
    if (sum !== 32'h23456789) begin
      errors++;
      $display("FAIL done_stall_sum: got %h want 23456789", sum);
    end
  endtask

  task automatic test_reset_abort();
    a = 32'hDEADBEEF; b = 32'h01010101; cin = 1'b1; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (start_ready !== 1'b1 || done_valid !== 1'b0 || busy !== 1'b0 ||
        sum !== 32'h0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: rdy=%b dv=%b busy=%b sum=%h cout=%b want 1 0 0 0 0",
               start_ready, done_valid, busy, sum, cout);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (done_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_done: got %b want 0", done_valid);
      end
    end
    do_op(32'h80000000, 32'h80000000, 1'b0, 0, "after_abort");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] av, bv;
      av = $urandom; bv = $urandom;
      if (i % 10 == 0) av = '1;
      do_op(av, bv, 1'($urandom), int'($urandom_range(0, 3)), "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_word_carry();
    test_full_ripple();
    test_done_stall();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/module_multiword_add_ctrl.md
MODULE_MULTIWORD_ADD_CTRL -- requirements
Module: module_multiword_add_ctrl

Interface
REQ-001 The block SHALL have parameter RCAWIDE, default 8, giving the width of the shared adder slice in bits (>=1).
REQ-002 The block SHALL have parameter NWORDS, default 4, giving the number of RCAWIDE-bit words per operand (>=1).
REQ-003 Port clk_i, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n_i, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port a_i, input, RCAWIDE*NWORDS bits: operand A; word k is bits [k*RCAWIDE +: RCAWIDE].
REQ-006 Port b_i, input, RCAWIDE*NWORDS bits: operand B, same word layout as a_i.
REQ-007 Port carry_i, input, 1 bit: carry-in to word 0.
REQ-008 Port start_valid_i, input, 1 bit: request to start an addition.
REQ-009 Port start_ready_o, output, 1 bit: block can accept a request.
REQ-010 Port sum_o, output, RCAWIDE*NWORDS bits: result sum.
REQ-011 Port carry_o, output, 1 bit: carry-out of the most significant word.
REQ-012 Port done_valid_o, output, 1 bit: sum_o and carry_o hold a completed result.
REQ-013 Port done_ready_i, input, 1 bit: consumer accepts the result.
REQ-014 Port busy_o, output, 1 bit: high in RUN and DONE.

Function
REQ-015 The block SHALL instantiate exactly one module_ripple_carry_adder of width RCAWIDE and compute the full-width sum serially, one word per clock, least significant word first.
REQ-016 The FSM SHALL have states IDLE, RUN and DONE; start_ready_o = (state==IDLE) and done_valid_o = (state==DONE), both decoded from registered state.
REQ-017 In IDLE, a clock edge with start_valid_i=1 SHALL capture a_i, b_i and carry_i into internal registers, clear the word index to 0, and enter RUN.
REQ-018 Each RUN cycle SHALL drive the adder with captured A word[idx], B word[idx] and the carry register, write its sum_o into result word[idx], load its carry_o into the carry register, and increment idx.
REQ-019 The block SHALL move from RUN to DONE on the edge that processes word NWORDS-1, so that RUN lasts exactly NWORDS cycles (one cycle when NWORDS=1).
REQ-020 done_valid_o SHALL rise exactly NWORDS rising edges after the accepting edge, with sum_o = (A+B+cin) mod 2^(RCAWIDE*NWORDS) and carry_o = bit RCAWIDE*NWORDS of A+B+cin.
REQ-021 In DONE, sum_o and carry_o SHALL remain stable until an edge with done_ready_i=1, which SHALL return the FSM to IDLE.
REQ-022 start_valid_i SHALL be ignored in RUN and DONE; captured operands SHALL be unaffected by input changes after acceptance.
REQ-023 sum_o and carry_o SHALL hold the last result in IDLE until the next accepted start; during RUN their contents are undefined to the consumer.
REQ-024 The minimum issue interval SHALL be NWORDS+2 cycles (accept, NWORDS RUN cycles, one DONE cycle with done_ready_i=1).
REQ-025 The word index SHALL be max(1,$clog2(NWORDS)) bits wide and SHALL never exceed NWORDS-1.

Reset
REQ-026 An edge with rst_n_i=0 SHALL force state IDLE, idx 0, carry register 0, sum_o 0, carry_o 0, done_valid_o 0, busy_o 0, start_ready_o 1, regardless of the current state.
REQ-027 A reset during RUN or DONE SHALL abort the operation with no done_valid_o pulse; the first request after reset SHALL complete correctly.

Verification (RCAWIDE=8, NWORDS=4)
REQ-028 Hold rst_n_i=0 for 2 edges -> start_ready_o=1, done_valid_o=0, busy_o=0, sum_o=0x00000000, carry_o=0.
REQ-029 a=0x000000FF, b=0x00000001, cin=0 -> done_valid_o rises 4 edges after accept; sum_o=0x00000100, carry_o=0.
REQ-030 a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum_o=0x00000000, carry_o=1 (carry ripples through all 4 words).
REQ-031 After a=0x12345678, b=0x11111111, cin=0, hold done_ready_i=0 for 10 cycles and pulse start_valid_i -> sum_o=0x23456789 stays stable, done_valid_o=1, start_ready_o=0, request ignored; done_ready_i=1 -> IDLE next edge.
REQ-032 Assert rst_n_i=0 after 2 RUN cycles -> IDLE, no done_valid_o; then a=0x80000000, b=0x80000000, cin=0 -> sum_o=0x00000000, carry_o=1.
REQ-033 Run 200 random back-to-back operations with random done_ready_i stalls -> every result matches {carry,sum}=a+b+cin and every issue interval is >=6 cycles.
